// File: rtl/rv32_instr_encoder_pkg.sv
// rv32_instr_encoder_pkg
// Shared definitions for the RV32I(+M) field-to-word encoder:
//   - opcode constants matching the ones the instruction decoder uses
//   - funct7 constants for the base, alternate (SUB/SRA) and M-extension groups
//   - the instruction format enum produced by the format checker
//   - the canonical NOP word (ADDI x0,x0,0) emitted in place of illegal bundles
//   - a helper that tests whether an immediate fits a signed field width
// Optional feature macro referenced by users of this package: RV32M_ENCODE_EN.
package rv32_instr_encoder_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_ISH,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_e;

   // An immediate fits a signed field of 'bits' width when every bit from
   // the field's sign position upward is a copy of that sign bit.
   function automatic logic fitsSigned(input logic [31:0] imm, input int bits);
      logic signed [31:0] upper;
      upper = $signed(imm) >>> (bits - 1);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/rv32_fmt_check.sv
// rv32_fmt_check
// Combinational format decode and legality check for one encoder field bundle.
// Ports:
//   i_op   [6:0]  opcode
//   i_func [9:0]  {funct7, funct3}
//   i_imm  [31:0] sign-extended byte immediate
//   o_fmt         instruction format (FMT_BAD for unknown opcodes)
//   o_err         bundle cannot be encoded legally
// Optional feature: RV32M_ENCODE_EN makes R-type funct7 0000001 (MUL..REMU) legal.
module rv32_fmt_check
   import rv32_instr_encoder_pkg::*;
(
   input  logic [6:0]  i_op,
   input  logic [9:0]  i_func,
   input  logic [31:0] i_imm,
   output fmt_e        o_fmt,
   output logic        o_err
);

   logic [6:0] w_f7;
   logic [2:0] w_f3;
   logic       w_legal;

   assign w_f7 = i_func[9:3];
   assign w_f3 = i_func[2:0];

   // Select the format from the opcode, then apply that format's field rules.
   // Shift-immediates are split out of I-ALU because their immediate is a
   // 5-bit shamt sharing the word with a funct7, not a 12-bit signed value.
   always_comb begin
      o_fmt   = FMT_BAD;
      w_legal = 1'b0;
      case (i_op)
         OP_REG: begin
            o_fmt   = FMT_R;
            w_legal = (w_f7 == F7_BASE) ||
                      ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)));
`ifdef RV32M_ENCODE_EN
            if (w_f7 == F7_MULDIV) begin
               w_legal = 1'b1;
            end
`endif
         end
         OP_IMM: begin
            if ((w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA)) begin
               o_fmt   = FMT_ISH;
               w_legal = (i_imm[31:5] == '0) &&
                         ((w_f7 == F7_BASE) || ((w_f7 == F7_ALT) && (w_f3 == F3_SRL_SRA)));
            end else begin
               o_fmt   = FMT_I;
               w_legal = fitsSigned(i_imm, 12);
            end
         end
         OP_LOAD, OP_JALR: begin
            o_fmt   = FMT_I;
            w_legal = fitsSigned(i_imm, 12);
         end
         OP_STORE: begin
            o_fmt   = FMT_S;
            w_legal = fitsSigned(i_imm, 12);
         end
         OP_BRANCH: begin
            o_fmt   = FMT_B;
            w_legal = fitsSigned(i_imm, 13) && !i_imm[0];
         end
         OP_LUI, OP_AUIPC: begin
            o_fmt   = FMT_U;
            w_legal = (i_imm[11:0] == '0);
         end
         OP_JAL: begin
            o_fmt   = FMT_J;
            w_legal = fitsSigned(i_imm, 21) && !i_imm[0];
         end
         default: begin
            o_fmt   = FMT_BAD;
            w_legal = 1'b0;
         end
      endcase
   end

   assign o_err = !w_legal;

endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder
// Two-stage RV32I(+M) field-to-word encoder with valid/ready handshakes.
// Stage 1 registers the field bundle with its decoded format and error flag,
// stage 2 registers the packed word. Illegal bundles become NOP words flagged
// with out_err and still consume an address slot so addresses track input order.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clr                   synchronous flush of both stages, address and counters
//   in_valid / in_ready   input handshake
//   in_op, in_func        opcode and {funct7, funct3}
//   in_rs1, in_rs2, in_rd register indices
//   in_imm                sign-extended byte immediate
//   out_valid / out_ready output handshake
//   out_instr, out_addr   encoded word and its byte address
//   out_err               word replaced by NOP because the bundle was illegal
//   instr_cnt, err_cnt    words emitted (wrapping) / error words (saturating)
// Optional feature macro: RV32M_ENCODE_EN (M-extension R-type encodings).
module rv32_instr_encoder
   import rv32_instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_op,
   input  logic [9:0]       in_func,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_addr,
   output logic             out_err,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic             r_s1Valid;
   logic [6:0]       r_s1Op;
   logic [9:0]       r_s1Func;
   logic [4:0]       r_s1Rs1;
   logic [4:0]       r_s1Rs2;
   logic [4:0]       r_s1Rd;
   logic [31:0]      r_s1Imm;
   fmt_e             r_s1Fmt;
   logic             r_s1Err;

   logic             r_s2Valid;
   logic [31:0]      r_s2Instr;
   logic             r_s2Err;

   logic [31:0]      r_addr;
   logic [CNT_W-1:0] r_instrCnt;
   logic [CNT_W-1:0] r_errCnt;

   logic             w_s1Adv;
   logic             w_s2Adv;
   logic             w_outXfer;
   fmt_e             w_fmt;
   logic             w_fmtErr;
   logic [6:0]       w_s1F7;
   logic [2:0]       w_s1F3;
   logic [31:0]      w_packed;

   // A stage may load when it is empty or its contents leave this cycle;
   // clr blocks acceptance so a flushed cycle never swallows a bundle.
   assign w_s2Adv   = !r_s2Valid || out_ready;
   assign w_s1Adv   = !r_s1Valid || w_s2Adv;
   assign in_ready  = w_s1Adv && !clr;
   assign w_outXfer = r_s2Valid && out_ready;

   rv32_fmt_check u_fmtCheck (
      .i_op   (in_op),
      .i_func (in_func),
      .i_imm  (in_imm),
      .o_fmt  (w_fmt),
      .o_err  (w_fmtErr)
   );

   assign w_s1F7 = r_s1Func[9:3];
   assign w_s1F3 = r_s1Func[2:0];

   // Standard RV32 bit placement for each format; B and J drop imm[0]
   // because their offsets are always even.
   always_comb begin
      w_packed = NOP_INSTR;
      case (r_s1Fmt)
         FMT_R:   w_packed = {w_s1F7, r_s1Rs2, r_s1Rs1, w_s1F3, r_s1Rd, r_s1Op};
         FMT_I:   w_packed = {r_s1Imm[11:0], r_s1Rs1, w_s1F3, r_s1Rd, r_s1Op};
         FMT_ISH: w_packed = {w_s1F7, r_s1Imm[4:0], r_s1Rs1, w_s1F3, r_s1Rd, r_s1Op};
         FMT_S:   w_packed = {r_s1Imm[11:5], r_s1Rs2, r_s1Rs1, w_s1F3, r_s1Imm[4:0], r_s1Op};
         FMT_B:   w_packed = {r_s1Imm[12], r_s1Imm[10:5], r_s1Rs2, r_s1Rs1, w_s1F3,
                              r_s1Imm[4:1], r_s1Imm[11], r_s1Op};
         FMT_U:   w_packed = {r_s1Imm[31:12], r_s1Rd, r_s1Op};
         FMT_J:   w_packed = {r_s1Imm[20], r_s1Imm[10:1], r_s1Imm[11], r_s1Imm[19:12],
                              r_s1Rd, r_s1Op};
         default: w_packed = NOP_INSTR;
      endcase
      if (r_s1Err) begin
         w_packed = NOP_INSTR;
      end
   end

   // Stage 1: capture the accepted bundle together with its format and
   // legality so stage 2 only has to pack bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Op    <= '0;
         r_s1Func  <= '0;
         r_s1Rs1   <= '0;
         r_s1Rs2   <= '0;
         r_s1Rd    <= '0;
         r_s1Imm   <= '0;
         r_s1Fmt   <= FMT_BAD;
         r_s1Err   <= 1'b0;
      end else if (clr) begin
         r_s1Valid <= 1'b0;
      end else if (w_s1Adv) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_s1Op   <= in_op;
            r_s1Func <= in_func;
            r_s1Rs1  <= in_rs1;
            r_s1Rs2  <= in_rs2;
            r_s1Rd   <= in_rd;
            r_s1Imm  <= in_imm;
            r_s1Fmt  <= w_fmt;
            r_s1Err  <= w_fmtErr;
         end
      end
   end

   // Stage 2: the output register. It only reloads when the current word
   // has been taken, which keeps out_instr/out_err stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_s2Instr <= '0;
         r_s2Err   <= 1'b0;
      end else if (clr) begin
         r_s2Valid <= 1'b0;
      end else if (w_s2Adv) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Instr <= w_packed;
            r_s2Err   <= r_s1Err;
         end
      end
   end

   // Address and statistics move only on an output transfer; clr takes
   // priority so a transfer in the flush cycle is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= BASE_ADDR;
         r_instrCnt <= '0;
         r_errCnt   <= '0;
      end else if (clr) begin
         r_addr     <= BASE_ADDR;
         r_instrCnt <= '0;
         r_errCnt   <= '0;
      end else if (w_outXfer) begin
         r_addr     <= r_addr + 32'd4;
         r_instrCnt <= r_instrCnt + CNT_W'(1);
         if (r_s2Err && (r_errCnt != '1)) begin
            r_errCnt <= r_errCnt + CNT_W'(1);
         end
      end
   end

   assign out_valid = r_s2Valid;
   assign out_instr = r_s2Instr;
   assign out_err   = r_s2Err;
   assign out_addr  = r_addr;
   assign instr_cnt = r_instrCnt;
   assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder
// Self-checking bench for rv32_instr_encoder: directed encodings, error words,
// backpressure, clr, randomized streams against a behavioural encoder model,
// and asynchronous reset in the middle of a stream.
// Honours RV32I_ENCODE option macro RV32M_ENCODE_EN for the MUL expectation.
module tb_rv32_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_op;
   logic [9:0]  in_func;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic [15:0] instr_cnt;
   logic [15:0] err_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lastAccCyc = 0;
   bit sendDone;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      int          cyc;
   } obs_t;

   typedef struct {
      logic [31:0] instr;
      bit          err;
   } exp_t;

   obs_t obsQ[$];
   exp_t expQ[$];

   rv32_instr_encoder #(
      .BASE_ADDR (BASE),
      .CNT_W     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_func   (in_func),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .instr_cnt (instr_cnt),
      .err_cnt   (err_cnt)
   );

   // Free-running clock and cycle counter used for latency measurements.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every completed output transfer, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && !clr && out_valid && out_ready) begin
         obsQ.push_back('{out_instr, out_addr, out_err, cyc});
      end
   end

   // Guard against a hung run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Behavioural encoder: legality from integer ranges, packing from
   // shifted field values.
   function automatic void refEncode(input logic [6:0] op, input logic [9:0] func,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [31:0] imm,
                                     output logic [31:0] word, output bit err);
      int unsigned opU, f7, f3, r1, r2, rdU;
      logic [31:0] u;
      int          s;
      bit          ok;
      bit          mext;
      logic [31:0] w;
      opU = op; f7 = func[9:3]; f3 = func[2:0];
      r1 = rs1; r2 = rs2; rdU = rd;
      u = imm; s = $signed(imm);
      ok = 0; w = 32'h13;
`ifdef RV32M_ENCODE_EN
      mext = 1;
`else
      mext = 0;
`endif
      case (opU)
         32'h33: begin
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (mext && f7 == 1);
            w  = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdU << 7) | opU;
         end
         32'h13: begin
            if (f3 == 1 || f3 == 5) begin
               ok = ((u >> 5) == 0) && (f7 == 0 || (f7 == 32 && f3 == 5));
               w  = (f7 << 25) | ((u & 31) << 20) | (r1 << 15) | (f3 << 12) | (rdU << 7) | opU;
            end else begin
               ok = (s >= -2048) && (s <= 2047);
               w  = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdU << 7) | opU;
            end
         end
         32'h03, 32'h67: begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rdU << 7) | opU;
         end
         32'h23: begin
            ok = (s >= -2048) && (s <= 2047);
            w  = (((u >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
                 ((u & 31) << 7) | opU;
         end
         32'h63: begin
            ok = (s >= -4096) && (s <= 4095) && ((u % 2) == 0);
            w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15) |
                 (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opU;
         end
         32'h37, 32'h17: begin
            ok = ((u % 4096) == 0);
            w  = (u & 32'hFFFFF000) | (rdU << 7) | opU;
         end
         32'h6F: begin
            ok = (s >= -1048576) && (s <= 1048575) && ((u % 2) == 0);
            w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
                 (((u >> 12) & 255) << 12) | (rdU << 7) | opU;
         end
         default: ok = 0;
      endcase
      word = ok ? w : 32'h0000_0013;
      err  = !ok;
   endfunction

   // Drive one bundle and hold it until the encoder accepts it; the expected
   // word is queued at the moment of acceptance.
   task automatic applyStimulus(input logic [6:0] op, input logic [9:0] func,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm);
      bit          acc;
      exp_t        e;
      logic [31:0] w;
      bit          er;
      acc = 0;
      in_op = op; in_func = func; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
      in_valid = 1'b1;
      for (int k = 0; k < 500 && !acc; k++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            refEncode(op, func, rs1, rs2, rd, imm, w, er);
            e.instr = w; e.err = er;
            expQ.push_back(e);
            lastAccCyc = cyc;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("[TB] FAIL accept_timeout in_ready=%0b required=1", in_ready);
      end
   endtask

   task automatic randomBundle(output logic [6:0] op, output logic [9:0] func,
                               output logic [4:0] rs1, output logic [4:0] rs2,
                               output logic [4:0] rd, output logic [31:0] imm);
      logic [31:0] r;
      logic [6:0]  f7;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: op = 7'b0110011;
         1: op = 7'b0010011;
         2: op = 7'b0000011;
         3: op = 7'b1100111;
         4: op = 7'b0100011;
         5: op = 7'b1100011;
         6: op = 7'b0110111;
         7: op = 7'b0010111;
         8: op = 7'b1101111;
         default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
         0, 1: f7 = 7'b0000000;
         2:    f7 = 7'b0100000;
         3:    f7 = 7'b0000001;
         default: f7 = 7'($urandom);
      endcase
      func = {f7, 3'($urandom)};
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      case ($urandom_range(0, 5))
         0: imm = {{20{r[11]}}, r[11:0]};
         1: imm = {{19{r[12]}}, r[12:1], 1'b0};
         2: imm = {{11{r[20]}}, r[20:1], 1'b0};
         3: imm = {r[31:12], 12'h000};
         4: imm = r;
         default: imm = {27'd0, r[4:0]};
      endcase
   endtask

   task automatic waitObs(input int n);
      for (int k = 0; k < 1000 && obsQ.size() < n; k++) @(negedge clk);
      checks++;
      if (obsQ.size() < n) begin
         failures++;
         $display("[TB] FAIL obs_timeout got=%0d words required=%0d", obsQ.size(), n);
      end
      @(posedge clk); #1;
   endtask

   task automatic doClr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      obsQ.delete();
      expQ.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_func = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h want=0", out_instr); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", out_err); end
      checks++; if (out_addr !== BASE) begin failures++; $display("[TB] FAIL reset_addr got=%h want=%h", out_addr, BASE); end
      checks++; if (instr_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d/%0d want=0/0", instr_cnt, err_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      doClr();
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd1, 32'd5);
      waitObs(1);
      checks++; if (obsQ[0].instr !== 32'h00500093) begin failures++; $display("[TB] FAIL addi_instr got=%h want=00500093", obsQ[0].instr); end
      checks++; if (obsQ[0].addr !== BASE || obsQ[0].err !== 1'b0) begin failures++; $display("[TB] FAIL addi_addr_err got=%h/%b want=%h/0", obsQ[0].addr, obsQ[0].err, BASE); end
      checks++; if (obsQ[0].cyc - lastAccCyc != 2) begin failures++; $display("[TB] FAIL addi_latency got=%0d want=2", obsQ[0].cyc - lastAccCyc); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wantI[3];
      doClr();
      wantI[0] = 32'h002081B3; wantI[1] = 32'h0020A423; wantI[2] = 32'h00208863;
      applyStimulus(7'b0110011, 10'b0000000_000, 5'd1, 5'd2, 5'd3, 32'd0);
      applyStimulus(7'b0100011, 10'b0000000_010, 5'd1, 5'd2, 5'd0, 32'd8);
      applyStimulus(7'b1100011, 10'b0000000_000, 5'd1, 5'd2, 5'd0, 32'd16);
      waitObs(3);
      for (int i = 0; i < 3 && i < obsQ.size(); i++) begin
         checks++; if (obsQ[i].instr !== wantI[i]) begin failures++; $display("[TB] FAIL b2b_instr%0d got=%h want=%h", i, obsQ[i].instr, wantI[i]); end
         checks++; if (obsQ[i].addr !== BASE + 32'(4 * i)) begin failures++; $display("[TB] FAIL b2b_addr%0d got=%h want=%h", i, obsQ[i].addr, BASE + 32'(4 * i)); end
         if (i > 0) begin
            checks++; if (obsQ[i].cyc != obsQ[i-1].cyc + 1) begin failures++; $display("[TB] FAIL b2b_gap%0d got=%0d want=1", i, obsQ[i].cyc - obsQ[i-1].cyc); end
         end
      end
   endtask

   task automatic test_lui_jal();
      doClr();
      applyStimulus(7'b0110111, 10'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
      applyStimulus(7'b1101111, 10'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
      waitObs(2);
      checks++; if (obsQ[0].instr !== 32'h123452B7) begin failures++; $display("[TB] FAIL lui_instr got=%h want=123452B7", obsQ[0].instr); end
      checks++; if (obsQ[1].instr !== 32'h001000EF) begin failures++; $display("[TB] FAIL jal_instr got=%h want=001000EF", obsQ[1].instr); end
   endtask

   task automatic test_errors();
      doClr();
      applyStimulus(7'b0010011, 10'd0, 5'd1, 5'd0, 5'd2, 32'd2048);
      applyStimulus(7'b1100011, 10'd0, 5'd1, 5'd2, 5'd0, 32'd3);
      applyStimulus(7'b1111111, 10'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      waitObs(3);
      for (int i = 0; i < 3 && i < obsQ.size(); i++) begin
         checks++; if (obsQ[i].instr !== 32'h00000013 || obsQ[i].err !== 1'b1) begin failures++; $display("[TB] FAIL err_word%0d got=%h/%b want=00000013/1", i, obsQ[i].instr, obsQ[i].err); end
      end
      checks++; if (err_cnt !== 16'd3) begin failures++; $display("[TB] FAIL err_cnt got=%0d want=3", err_cnt); end
      checks++; if (instr_cnt !== 16'd3) begin failures++; $display("[TB] FAIL err_instr_cnt got=%0d want=3", instr_cnt); end
   endtask

   task automatic test_mul();
      logic [31:0] wantI;
      logic        wantE;
`ifdef RV32M_ENCODE_EN
      wantI = 32'h022081B3; wantE = 1'b0;
`else
      wantI = 32'h00000013; wantE = 1'b1;
`endif
      doClr();
      applyStimulus(7'b0110011, 10'b0000001_000, 5'd1, 5'd2, 5'd3, 32'd0);
      waitObs(1);
      checks++; if (obsQ[0].instr !== wantI || obsQ[0].err !== wantE) begin failures++; $display("[TB] FAIL mul got=%h/%b want=%h/%b", obsQ[0].instr, obsQ[0].err, wantI, wantE); end
   endtask

   task automatic test_backpressure();
      logic [6:0]  op; logic [9:0] fn; logic [4:0] a, b, d; logic [31:0] im;
      logic [31:0] heldI, heldA;
      logic        heldE;
      doClr();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               randomBundle(op, fn, a, b, d, im);
               applyStimulus(op, fn, a, b, d, im);
            end
         end
         begin
            repeat (3) @(negedge clk);
            heldI = out_instr; heldA = out_addr; heldE = out_err;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid got=%b want=1", out_valid); end
            repeat (2) begin
               @(negedge clk);
               checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready got=%b want=0", in_ready); end
               checks++; if (out_instr !== heldI || out_addr !== heldA || out_err !== heldE) begin failures++; $display("[TB] FAIL bp_stable got=%h@%h want=%h@%h", out_instr, out_addr, heldI, heldA); end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      waitObs(4);
      repeat (5) @(posedge clk); #1;
      checks++; if (obsQ.size() != 4) begin failures++; $display("[TB] FAIL bp_count got=%0d want=4", obsQ.size()); end
      for (int i = 0; i < 4 && i < obsQ.size() && i < expQ.size(); i++) begin
         checks++; if (obsQ[i].instr !== expQ[i].instr || obsQ[i].err !== expQ[i].err) begin failures++; $display("[TB] FAIL bp_word%0d got=%h/%b want=%h/%b", i, obsQ[i].instr, obsQ[i].err, expQ[i].instr, expQ[i].err); end
         checks++; if (obsQ[i].addr !== BASE + 32'(4 * i)) begin failures++; $display("[TB] FAIL bp_addr%0d got=%h want=%h", i, obsQ[i].addr, BASE + 32'(4 * i)); end
      end
   endtask

   task automatic test_clr();
      doClr();
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd1, 32'd1);
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd2, 32'd2);
      clr = 1'b1; in_valid = 1'b1; in_op = 7'b0010011; in_imm = 32'd3;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL clr_in_ready got=%b want=0", in_ready); end
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      obsQ.delete(); expQ.delete();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_valid got=%b want=0", out_valid); end
      checks++; if (instr_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL clr_cnt got=%0d/%0d want=0/0", instr_cnt, err_cnt); end
      @(posedge clk); #1;
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd1, 32'd5);
      waitObs(1);
      repeat (4) @(posedge clk); #1;
      checks++; if (obsQ.size() != 1) begin failures++; $display("[TB] FAIL clr_stale got=%0d words want=1", obsQ.size()); end
      checks++; if (obsQ[0].addr !== BASE || obsQ[0].instr !== 32'h00500093) begin failures++; $display("[TB] FAIL clr_next got=%h@%h want=00500093@%h", obsQ[0].instr, obsQ[0].addr, BASE); end
      checks++; if (instr_cnt !== 16'd1) begin failures++; $display("[TB] FAIL clr_count got=%0d want=1", instr_cnt); end
   endtask

   task automatic test_random();
      localparam int N = 150;
      logic [6:0]  op; logic [9:0] fn; logic [4:0] a, b, d; logic [31:0] im;
      int          nErr;
      doClr();
      sendDone = 0;
      fork
         begin
            for (int i = 0; i < N; i++) begin
               randomBundle(op, fn, a, b, d, im);
               applyStimulus(op, fn, a, b, d, im);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            sendDone = 1;
         end
         begin
            for (int k = 0; k < 5000 && !sendDone; k++) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      waitObs(N);
      repeat (3) @(posedge clk); #1;
      nErr = 0;
      for (int i = 0; i < expQ.size(); i++) if (expQ[i].err) nErr++;
      checks++; if (obsQ.size() != N) begin failures++; $display("[TB] FAIL rnd_count got=%0d want=%0d", obsQ.size(), N); end
      for (int i = 0; i < N && i < obsQ.size() && i < expQ.size(); i++) begin
         checks++; if (obsQ[i].instr !== expQ[i].instr || obsQ[i].err !== expQ[i].err) begin failures++; $display("[TB] FAIL rnd_word%0d got=%h/%b want=%h/%b", i, obsQ[i].instr, obsQ[i].err, expQ[i].instr, expQ[i].err); end
         checks++; if (obsQ[i].addr !== BASE + 32'(4 * i)) begin failures++; $display("[TB] FAIL rnd_addr%0d got=%h want=%h", i, obsQ[i].addr, BASE + 32'(4 * i)); end
      end
      checks++; if (instr_cnt !== 16'(N)) begin failures++; $display("[TB] FAIL rnd_instr_cnt got=%0d want=%0d", instr_cnt, N); end
      checks++; if (err_cnt !== 16'(nErr)) begin failures++; $display("[TB] FAIL rnd_err_cnt got=%0d want=%0d", err_cnt, nErr); end
   endtask

   task automatic test_async_reset();
      doClr();
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd1, 32'd7);
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd2, 32'd8);
      applyStimulus(7'b0010011, 10'd0, 5'd0, 5'd0, 5'd3, 32'd9);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin failures++; $display("[TB] FAIL areset_out got=%b/%h want=0/00000000", out_valid, out_instr); end
      checks++; if (out_addr !== BASE || instr_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL areset_state got=%h/%0d want=%h/0", out_addr, instr_cnt, BASE); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_lost got=%b want=0", out_valid); end
      end
      @(posedge clk); #1;
   endtask

   task automatic checkOutput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_lui_jal();
      test_errors();
      test_mul();
      test_backpressure();
      test_clr();
      test_random();
      test_async_reset();
      checkOutput();
      $finish;
   end

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Field-to-word RV32I(+M) instruction encoder; inverse of the instruction decoder.
- Accepts a field bundle (op, func, rs1, rs2, rd, imm) in the same packing the decoder emits.
- Validates the bundle and packs a 32-bit instruction word tagged with a running byte address.
- Feeds the IMEM program loader and self-check benches that round-trip through the decoder.

Parameters:
- BASE_ADDR, 32'h0000_0000, address tagged on the first instruction after reset or clr.
- CNT_W, 16, width of the instruction and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: empties pipeline, reloads address, zeroes counters.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_op  in  7  opcode.
- in_func  in  10  {funct7, funct3}; funct7 is ignored for non-R and non-shift formats.
- in_rs1, in_rs2, in_rd  in  5 each  register indices; unused fields are ignored.
- in_imm  in  32  immediate, fully sign-extended byte value; B/J offsets are in bytes.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- out_err  out  1  bundle was illegal; out_instr is forced to NOP 32'h0000_0013.
- instr_cnt  out  CNT_W  words emitted; wraps.
- err_cnt  out  CNT_W  error words emitted; saturates at all-ones.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_instr=0, out_err=0.
  - out_addr=BASE_ADDR, both counters=0, both pipeline stages empty.
- Pipeline, two stages:
  - S1 registers the fields plus decoded format and error flag.
  - S2 registers the packed word.
  - Latency: acceptance in cycle N gives out_valid in cycle N+2 with out_ready high.
  - Throughput: one word per cycle.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - S2 advance = !s2_valid | out_ready. S1 advance = !s1_valid | S2 advance. in_ready = S1 advance & !clr.
  - out_instr, out_addr and out_err hold stable while out_valid & !out_ready.
- Format select by op:
  - 0110011 R.
  - 0010011 I-ALU; 0000011 LOAD; 1100111 JALR (I).
  - 0100011 S; 1100011 B.
  - 0110111 LUI; 0010111 AUIPC (U).
  - 1101111 J.
  - Any other op: error.
- Legality checks (failure sets error):
  - R: funct7 is 0000000, or 0100000 only with funct3 000 or 101.
  - I shift (op 0010011, funct3 001/101): imm[31:5]==0. funct7 0000000; 0100000 is allowed only for funct3 101. Word = {funct7, imm[4:0], rs1, funct3, rd, op}.
  - Other I: imm fits signed 12 bits.
  - S: imm fits signed 12 bits.
  - B: imm fits signed 13 bits and imm[0]==0.
  - U: imm[11:0]==0.
  - J: imm fits signed 21 bits and imm[0]==0.
- Packing follows the standard RV32 bit placement per format.
- Error words:
  - Emitted in stream order, not dropped, with out_err=1.
  - Address still advances, so addresses stay aligned to input order.
- Address and counters:
  - out_addr += 4 after each output transfer; wraps modulo 2^32.
  - instr_cnt +1 per output transfer.
  - err_cnt +1 per transfer with out_err=1.
- clr:
  - Drops both stages, including an out_valid word stalled by backpressure.
  - Reloads BASE_ADDR, zeroes counters.
  - clr with in_valid in the same cycle: bundle is not accepted.
  - clr with an output transfer in the same cycle: clr wins, and the counters read 0 next cycle.
- rst_n asserted mid-stream: everything returns to reset values immediately; in-flight words are lost.

Optional Feature:
- Macro: RV32M_ENCODE_EN.
- When defined: R-type with funct7 0000001 and any funct3 is legal and packed normally (MUL..REMU).
- When undefined: funct7 0000001 is an error.

Decomposition:
- Shared package/include holds:
  - opcode constants (the RV32I/RV32M defines already used by the decoder);
  - a format enum {R, I, ISH, S, B, U, J, BAD};
  - NOP constant 32'h0000_0013.
- One sub-module is natural: rv32_fmt_check, combinational; op/func/imm in, format + error flag out, used in S1.
- Packing and the handshake stay in the top module.

Test Plan:
- ADDI x1,x0,5 (op 0010011, func 0, rd 1, imm 5) -> out_instr 0x00500093, out_addr BASE_ADDR, out_err 0, 2 cycles after acceptance.
- Back-to-back ADD x3,x1,x2 / SW x2,8(x1) / BEQ x1,x2,+16, out_ready held high:
  - outputs 0x002081B3, 0x0020A423, 0x00208863 on consecutive cycles;
  - out_addr 0x0, 0x4, 0x8.
- LUI x5,0x12345000 -> 0x123452B7. JAL x1,+2048 -> 0x001000EF.
- ADDI imm 2048, BEQ imm 3, and op 1111111 -> each emits 0x00000013 with out_err=1; err_cnt=3.
- Backpressure:
  - out_ready low 5 cycles while streaming 4 bundles; in_ready drops once both stages are full.
  - Outputs stay stable, then all 4 are delivered in order with no loss or duplication.
- MUL x3,x1,x2 (func 0000001_000):
  - RV32M_ENCODE_EN defined -> 0x022081B3.
  - Undefined -> NOP with out_err=1.
  - clr asserted mid-stream -> out_valid 0 next cycle, next word tagged BASE_ADDR, counters 0.
